// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter slice.
// The bus command encoding is common to every memory-side client.
package mem_bus_arbiter_pkg;

  localparam int TAG_BITS    = 4;
  localparam int NUM_TAGS    = 2 ** TAG_BITS;
  localparam int STARVE_BITS = 3;
  localparam logic [STARVE_BITS-1:0] STARVE_LIMIT = 3'd4;
  localparam logic [STARVE_BITS-1:0] STARVE_MAX   = 3'd7;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_DCACHE = 1'b0,
    OWNER_ICACHE = 1'b1
  } MEM_OWNER;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// Per-tag ownership record for outstanding loads: one set port, one lookup/clear port.
// A set and a clear on the same tag in one cycle leave the entry set with the new owner.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                set_en,
  input  logic [TAG_BITS-1:0] set_tag,
  input  MEM_OWNER            set_owner,
  input  logic                clear_en,
  input  logic [TAG_BITS-1:0] lookup_tag,
  output logic                lookup_valid,
  output MEM_OWNER            lookup_owner
);

  logic [NUM_TAGS-1:0] own_valid_r;
  logic [NUM_TAGS-1:0] own_icache_r;

  assign lookup_valid = own_valid_r[lookup_tag];
  assign lookup_owner = own_icache_r[lookup_tag] ? OWNER_ICACHE : OWNER_DCACHE;

  // Entry update: set has priority over clear on the same tag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      own_valid_r  <= '0;
      own_icache_r <= '0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (set_en && (set_tag == TAG_BITS'(i))) begin
          own_valid_r[i]  <= 1'b1;
          own_icache_r[i] <= (set_owner == OWNER_ICACHE);
        end else if (clear_en && (lookup_tag == TAG_BITS'(i))) begin
          own_valid_r[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between icache and dcache, with sticky grant on back-pressure,
// icache anti-starvation, and tag-based routing of returning load data.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  BUS_COMMAND          dcache_command,
  input  logic [63:0]         dcache_addr,
  input  logic [63:0]         dcache_data,
  input  BUS_COMMAND          icache_command,
  input  logic [63:0]         icache_addr,
  output BUS_COMMAND          proc2mem_command,
  output logic [63:0]         proc2mem_addr,
  output logic [63:0]         proc2mem_data,
  input  logic [TAG_BITS-1:0] mem2proc_response,
  input  logic [63:0]         mem2proc_data,
  input  logic [TAG_BITS-1:0] mem2proc_tag,
  output logic [TAG_BITS-1:0] dcache_response,
  output logic [TAG_BITS-1:0] icache_response,
  output logic [TAG_BITS-1:0] dcache_tag,
  output logic [TAG_BITS-1:0] icache_tag,
  output logic [63:0]         dcache_rdata,
  output logic [63:0]         icache_rdata,
  output logic                grant_icache,
  output logic                orphan_tag
);

  logic                   dcache_req_s;
  logic                   icache_req_s;
  logic                   held_req_s;
  logic                   grant_valid_s;
  MEM_OWNER               grant_owner_s;
  logic                   accept_s;
  logic                   ret_nz_s;
  logic                   lookup_valid_s;
  MEM_OWNER               lookup_owner_s;
  logic                   hold_valid_r;
  MEM_OWNER               hold_owner_r;
  logic [STARVE_BITS-1:0] starve_cnt_r;

  assign dcache_req_s = (dcache_command != BUS_NONE);
  assign icache_req_s = (icache_command != BUS_NONE);
  assign held_req_s   = (hold_owner_r == OWNER_ICACHE) ? icache_req_s : dcache_req_s;
  assign accept_s     = grant_valid_s && (mem2proc_response != {TAG_BITS{1'b0}});
  assign ret_nz_s     = (mem2proc_tag != {TAG_BITS{1'b0}});
  assign dcache_rdata = mem2proc_data;
  assign icache_rdata = mem2proc_data;

  // Grant selection: held owner first, then sole requester, then starvation-aware tie-break.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_owner_s = OWNER_DCACHE;
    if (hold_valid_r && held_req_s) begin
      grant_valid_s = 1'b1;
      grant_owner_s = hold_owner_r;
    end else if (dcache_req_s && icache_req_s) begin
      grant_valid_s = 1'b1;
      grant_owner_s = (starve_cnt_r >= STARVE_LIMIT) ? OWNER_ICACHE : OWNER_DCACHE;
    end else if (icache_req_s) begin
      grant_valid_s = 1'b1;
      grant_owner_s = OWNER_ICACHE;
    end else if (dcache_req_s) begin
      grant_valid_s = 1'b1;
      grant_owner_s = OWNER_DCACHE;
    end else begin
      grant_valid_s = 1'b0;
      grant_owner_s = OWNER_DCACHE;
    end
  end

  // Bus mux and acceptance-tag steering toward the granted requester.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 64'h0;
    proc2mem_data    = 64'h0;
    dcache_response  = {TAG_BITS{1'b0}};
    icache_response  = {TAG_BITS{1'b0}};
    grant_icache     = 1'b0;
    if (grant_valid_s && (grant_owner_s == OWNER_ICACHE)) begin
      proc2mem_command = icache_command;
      proc2mem_addr    = icache_addr;
      icache_response  = mem2proc_response;
      grant_icache     = 1'b1;
    end else if (grant_valid_s) begin
      proc2mem_command = dcache_command;
      proc2mem_addr    = dcache_addr;
      proc2mem_data    = dcache_data;
      dcache_response  = mem2proc_response;
    end else begin
      proc2mem_command = BUS_NONE;
    end
  end

  // Return routing: the owner recorded before this cycle's update decides the destination.
  always_comb begin
    dcache_tag = {TAG_BITS{1'b0}};
    icache_tag = {TAG_BITS{1'b0}};
    orphan_tag = 1'b0;
    if (ret_nz_s && lookup_valid_s) begin
      if (lookup_owner_s == OWNER_ICACHE) begin
        icache_tag = mem2proc_tag;
      end else begin
        dcache_tag = mem2proc_tag;
      end
    end else if (ret_nz_s) begin
      orphan_tag = 1'b1;
    end else begin
      orphan_tag = 1'b0;
    end
  end

  // Sticky grant on rejection and saturating icache starvation counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid_r <= 1'b0;
      hold_owner_r <= OWNER_DCACHE;
      starve_cnt_r <= 3'd0;
    end else begin
      if (accept_s || !grant_valid_s) begin
        hold_valid_r <= 1'b0;
      end else begin
        hold_valid_r <= 1'b1;
        hold_owner_r <= grant_owner_s;
      end
      if (!icache_req_s || (accept_s && (grant_owner_s == OWNER_ICACHE))) begin
        starve_cnt_r <= 3'd0;
      end else if (starve_cnt_r != STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + 3'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  mem_tag_owner_table u_owner_table (
    .clock        (clock),
    .reset        (reset),
    .set_en       (accept_s && (proc2mem_command == BUS_LOAD)),
    .set_tag      (mem2proc_response),
    .set_owner    (grant_owner_s),
    .clear_en     (ret_nz_s && lookup_valid_s),
    .lookup_tag   (mem2proc_tag),
    .lookup_valid (lookup_valid_s),
    .lookup_owner (lookup_owner_s)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed table, randomized model-checked traffic, and a reset-in-flight sequence
// for mem_bus_arbiter.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  BUS_COMMAND  dcache_command, icache_command, proc2mem_command;
  logic [63:0] dcache_addr, dcache_data, icache_addr, proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data, dcache_rdata, icache_rdata;
  logic [3:0]  dcache_response, icache_response, dcache_tag, icache_tag;
  logic        grant_icache, orphan_tag;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: which tags are outstanding and who asked for them,
  // who (if anyone) is holding the bus after a rejection, and how long icache has waited.
  bit m_valid[16];
  bit m_icache[16];
  int m_hold;    // -1 none, 0 dcache, 1 icache
  int m_starve;

  typedef struct {
    BUS_COMMAND  dc, ic;
    logic [63:0] da, ia;
    logic [3:0]  rs, rt;
    logic [63:0] rd;
    BUS_COMMAND  ec;
    logic [63:0] ea;
    logic [3:0]  edr, eir;
    logic        eg;
    logic [3:0]  edt, eit;
    logic        eo;
  } vec_t;

  vec_t tbl[19];

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .icache_command(icache_command), .icache_addr(icache_addr),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .dcache_response(dcache_response), .icache_response(icache_response),
    .dcache_tag(dcache_tag), .icache_tag(icache_tag),
    .dcache_rdata(dcache_rdata), .icache_rdata(icache_rdata),
    .grant_icache(grant_icache), .orphan_tag(orphan_tag)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(BUS_COMMAND dc, BUS_COMMAND ic, logic [63:0] da, logic [63:0] ia,
                              logic [3:0] rs, logic [3:0] rt, logic [63:0] rd,
                              BUS_COMMAND ec, logic [63:0] ea, logic [3:0] edr, logic [3:0] eir,
                              logic eg, logic [3:0] edt, logic [3:0] eit, logic eo);
    vec_t v;
    v.dc = dc; v.ic = ic; v.da = da; v.ia = ia; v.rs = rs; v.rt = rt; v.rd = rd;
    v.ec = ec; v.ea = ea; v.edr = edr; v.eir = eir; v.eg = eg;
    v.edt = edt; v.eit = eit; v.eo = eo;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(BUS_COMMAND dc, BUS_COMMAND ic, logic [63:0] da, logic [63:0] ia,
                       logic [3:0] rs, logic [3:0] rt, logic [63:0] rd);
    dcache_command    = dc;
    icache_command    = ic;
    dcache_addr       = da;
    dcache_data       = da ^ 64'hA5A5_0000_5A5A_FFFF;
    icache_addr       = ia;
    mem2proc_response = rs;
    mem2proc_tag      = rt;
    mem2proc_data     = rd;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_icache[i] = 1'b0;
    end
    m_hold   = -1;
    m_starve = 0;
  endtask

  function automatic int m_grant();
    bit dr = (dcache_command != BUS_NONE);
    bit ir = (icache_command != BUS_NONE);
    if ((m_hold == 1 && ir) || (m_hold == 0 && dr)) return m_hold;
    if (dr && ir) return (m_starve >= 4) ? 1 : 0;
    if (dr) return 0;
    if (ir) return 1;
    return -1;
  endfunction

  task automatic check_model();
    int          g;
    logic [63:0] e_cmd, e_addr, e_data;
    logic [3:0]  e_dr, e_ir, e_dt, e_it;
    logic        e_or;
    g      = m_grant();
    e_cmd  = 64'(BUS_NONE);
    e_addr = 64'h0;
    e_data = 64'h0;
    e_dr   = 4'd0;
    e_ir   = 4'd0;
    if (g == 0) begin
      e_cmd = 64'(dcache_command); e_addr = dcache_addr; e_data = dcache_data;
      e_dr = mem2proc_response;
    end else if (g == 1) begin
      e_cmd = 64'(icache_command); e_addr = icache_addr; e_ir = mem2proc_response;
    end
    e_dt = 4'd0; e_it = 4'd0; e_or = 1'b0;
    if (mem2proc_tag != 4'd0) begin
      if (!m_valid[mem2proc_tag]) e_or = 1'b1;
      else if (m_icache[mem2proc_tag]) e_it = mem2proc_tag;
      else e_dt = mem2proc_tag;
    end
    check("m_cmd", 64'(proc2mem_command), e_cmd);
    check("m_addr", proc2mem_addr, e_addr);
    check("m_data", proc2mem_data, e_data);
    check("m_dresp", 64'(dcache_response), 64'(e_dr));
    check("m_iresp", 64'(icache_response), 64'(e_ir));
    check("m_grant_i", 64'(grant_icache), (g == 1) ? 64'h1 : 64'h0);
    check("m_dtag", 64'(dcache_tag), 64'(e_dt));
    check("m_itag", 64'(icache_tag), 64'(e_it));
    check("m_orphan", 64'(orphan_tag), 64'(e_or));
    check("m_drdata", dcache_rdata, mem2proc_data);
    check("m_irdata", icache_rdata, mem2proc_data);
  endtask

  task automatic model_update();
    int         g;
    bit         acc;
    BUS_COMMAND gc;
    g   = m_grant();
    acc = (g >= 0) && (mem2proc_response != 4'd0);
    gc  = (g == 1) ? icache_command : dcache_command;
    if (mem2proc_tag != 4'd0 && m_valid[mem2proc_tag]) m_valid[mem2proc_tag] = 1'b0;
    if (acc && gc == BUS_LOAD) begin
      m_valid[mem2proc_response]  = 1'b1;
      m_icache[mem2proc_response] = (g == 1);
    end
    m_hold = acc ? -1 : g;
    if (icache_command == BUS_NONE || (acc && g == 1)) m_starve = 0;
    else if (m_starve < 7) m_starve++;
  endtask

  task automatic step(BUS_COMMAND dc, BUS_COMMAND ic, logic [63:0] da, logic [63:0] ia,
                      logic [3:0] rs, logic [3:0] rt, logic [63:0] rd);
    @(negedge clock);
    drive(dc, ic, da, ia, rs, rt, rd);
    #1;
    check_model();
    model_update();
  endtask

  initial begin
    tbl[0]  = mk(BUS_NONE, BUS_NONE, 64'h999, 64'h888, 4'd0, 4'd0, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    tbl[1]  = mk(BUS_LOAD, BUS_NONE, 64'h100, 64'h888, 4'd3, 4'd0, 64'h0, BUS_LOAD, 64'h100, 4'd3, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    tbl[2]  = mk(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd3, 64'hDEAD, BUS_NONE, 64'h0, 4'd0, 4'd0, 1'b0, 4'd3, 4'd0, 1'b0);
    tbl[3]  = mk(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd3, 64'h1111, BUS_NONE, 64'h0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    tbl[4]  = mk(BUS_LOAD, BUS_LOAD, 64'h110, 64'h210, 4'd1, 4'd0, 64'h0, BUS_LOAD, 64'h110, 4'd1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    tbl[5]  = mk(BUS_LOAD, BUS_LOAD, 64'h111, 64'h210, 4'd4, 4'd0, 64'h0, BUS_LOAD, 64'h111, 4'd4, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    tbl[6]  = mk(BUS_LOAD, BUS_LOAD, 64'h112, 64'h210, 4'd6, 4'd0, 64'h0, BUS_LOAD, 64'h112, 4'd6, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    tbl[7]  = mk(BUS_LOAD, BUS_LOAD, 64'h113, 64'h210, 4'd8, 4'd0, 64'h0, BUS_LOAD, 64'h113, 4'd8, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    tbl[8]  = mk(BUS_LOAD, BUS_LOAD, 64'h114, 64'h210, 4'd2, 4'd0, 64'h0, BUS_LOAD, 64'h210, 4'd0, 4'd2, 1'b1, 4'd0, 4'd0, 1'b0);
    tbl[9]  = mk(BUS_LOAD, BUS_LOAD, 64'h118, 64'h214, 4'd11, 4'd0, 64'h0, BUS_LOAD, 64'h118, 4'd11, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    tbl[10] = mk(BUS_NONE, BUS_LOAD, 64'h11C, 64'h220, 4'd0, 4'd0, 64'h0, BUS_LOAD, 64'h220, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0);
    tbl[11] = mk(BUS_LOAD, BUS_LOAD, 64'h120, 64'h220, 4'd0, 4'd0, 64'h0, BUS_LOAD, 64'h220, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0);
    tbl[12] = mk(BUS_LOAD, BUS_LOAD, 64'h120, 64'h220, 4'd5, 4'd0, 64'h0, BUS_LOAD, 64'h220, 4'd0, 4'd5, 1'b1, 4'd0, 4'd0, 1'b0);
    tbl[13] = mk(BUS_STORE, BUS_NONE, 64'h300, 64'h0, 4'd7, 4'd0, 64'h0, BUS_STORE, 64'h300, 4'd7, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    tbl[14] = mk(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd7, 64'h77, BUS_NONE, 64'h0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    tbl[15] = mk(BUS_LOAD, BUS_NONE, 64'h400, 64'h0, 4'd2, 4'd2, 64'hBEEF, BUS_LOAD, 64'h400, 4'd2, 4'd0, 1'b0, 4'd0, 4'd2, 1'b0);
    tbl[16] = mk(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd2, 64'h2222, BUS_NONE, 64'h0, 4'd0, 4'd0, 1'b0, 4'd2, 4'd0, 1'b0);
    tbl[17] = mk(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd5, 64'h5555, BUS_NONE, 64'h0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd5, 1'b0);
    tbl[18] = mk(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd1, 64'h1234, BUS_NONE, 64'h0, 4'd0, 4'd0, 1'b0, 4'd1, 4'd0, 1'b0);

    // Reset: an unowned returning tag is an orphan and no requester sees it.
    reset = 1'b0;
    drive(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd4, 64'h0);
    model_reset();
    #12;
    check("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    check("rst_dtag", 64'(dcache_tag), 64'h0);
    check("rst_itag", 64'(icache_tag), 64'h0);
    check("rst_orphan", 64'(orphan_tag), 64'h1);
    @(negedge clock);
    reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      drive(tbl[i].dc, tbl[i].ic, tbl[i].da, tbl[i].ia, tbl[i].rs, tbl[i].rt, tbl[i].rd);
      #1;
      check("t_cmd", 64'(proc2mem_command), 64'(tbl[i].ec));
      check("t_addr", proc2mem_addr, tbl[i].ea);
      check("t_dresp", 64'(dcache_response), 64'(tbl[i].edr));
      check("t_iresp", 64'(icache_response), 64'(tbl[i].eir));
      check("t_grant_i", 64'(grant_icache), 64'(tbl[i].eg));
      check("t_dtag", 64'(dcache_tag), 64'(tbl[i].edt));
      check("t_itag", 64'(icache_tag), 64'(tbl[i].eit));
      check("t_orphan", 64'(orphan_tag), 64'(tbl[i].eo));
      check("t_drdata", dcache_rdata, tbl[i].rd);
      model_update();
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      BUS_COMMAND dc, ic;
      logic [3:0] rs, rt;
      dc = BUS_COMMAND'(2'($urandom_range(2, 0)));
      ic = ($urandom_range(1, 0) == 1) ? BUS_LOAD : BUS_NONE;
      rs = ($urandom_range(9, 0) < 3) ? 4'd0 : 4'($urandom_range(15, 1));
      rt = ($urandom_range(1, 0) == 1) ? 4'd0 : 4'($urandom_range(15, 0));
      step(dc, ic, {$urandom, $urandom}, {$urandom, $urandom}, rs, rt, {$urandom, $urandom});
    end

    // Reset with an icache load in flight and starvation partly built up.
    step(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    step(BUS_NONE, BUS_LOAD, 64'h0, 64'h900, 4'd9, 4'd0, 64'h0);
    step(BUS_LOAD, BUS_LOAD, 64'h500, 64'h910, 4'd12, 4'd0, 64'h0);
    step(BUS_LOAD, BUS_LOAD, 64'h508, 64'h910, 4'd13, 4'd0, 64'h0);
    step(BUS_LOAD, BUS_LOAD, 64'h510, 64'h910, 4'd14, 4'd0, 64'h0);
    @(negedge clock);
    drive(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    #3;
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(BUS_LOAD, BUS_LOAD, 64'h600 + 64'(k), 64'h700, 4'(k + 1), 4'd0, 64'h0);
      check("rst_starve_grant_i", 64'(grant_icache), 64'h0);
    end
    step(BUS_LOAD, BUS_LOAD, 64'h610, 64'h700, 4'd6, 4'd0, 64'h0);
    check("rst_starve_5th_i", 64'(grant_icache), 64'h1);
    step(BUS_NONE, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd9, 64'h9999);
    check("inflight_orphan", 64'(orphan_tag), 64'h1);
    check("inflight_itag", 64'(icache_tag), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
